medidor_proximidade_duplo: RTL and testbench
============================================

# medidor_proximidade_duplo

Dual ultrasonic ranging sequencer that feeds the left/right proximity comparator stage. On each `medir` request it triggers the left sensor, times its echo, waits a guard interval, then does the same for the right sensor. It converts each echo width to a 3-digit BCD distance in centimetres on `medida_esq` / `medida_dir` (12 bits each). It also raises `medidas_validas`, which the system ANDs into the alarm-enable path so no alarm fires before real data exists.

## Interface
- `TRIGGER_CYCLES`, 500: trigger pulse width in clocks (10 us at 50 MHz).
- `CYCLES_PER_CM`, 2941: echo clocks per centimetre (58.82 us at 50 MHz); must be ≥ 2.
- `TIMEOUT_CYCLES`, 1_500_000: maximum clocks from trigger fall to echo fall (30 ms).
- `GAP_CYCLES`, 3_000_000: guard interval between the left echo end and the right trigger (60 ms).
- `clock` in 1: single system clock. One clock; reset is synchronous and active-low.
- `reset` in 1: synchronous, active-low, sampled on the rising edge of `clock`.
- `medir` in 1: start request, level or pulse; sampled only in IDLE.
- `echo_esq` in 1: left sensor echo, asynchronous.
- `echo_dir` in 1: right sensor echo, asynchronous.
- `trigger_esq` out 1: left sensor trigger.
- `trigger_dir` out 1: right sensor trigger.
- `medida_esq` out 12: left distance, BCD {hundreds, tens, units} in cm.
- `medida_dir` out 12: right distance, BCD.
- `timeout_esq` out 1: last left measurement timed out.
- `timeout_dir` out 1: last right measurement timed out.
- `ocupado` out 1: high in every state except IDLE.
- `pronto` out 1: one-cycle pulse when both sides have been updated.
- `medidas_validas` out 1: sticky; set on the first `pronto`, cleared only by reset.

## Operation
- Both echoes go through a 2-flop synchroniser. All echo logic uses the synchronised signals only.
- FSM states and transitions:
  - IDLE: go to TRIG_ESQ when `medir` = 1.
  - TRIG_ESQ: `trigger_esq` = 1 for exactly TRIGGER_CYCLES clocks, then go to WAIT_ESQ.
  - WAIT_ESQ: wait for a 0→1 edge on the synchronised echo, then go to MEAS_ESQ.
  - MEAS_ESQ: count echo-high clocks N. On the 1→0 edge, go to STORE_ESQ.
  - STORE_ESQ: go to GAP.
  - GAP: wait GAP_CYCLES clocks, then go to TRIG_DIR.
  - TRIG_DIR → WAIT_DIR → MEAS_DIR → STORE_DIR: same as the left side, using the right signals.
  - STORE_DIR → DONE → IDLE.
- Timeout:
  - A single counter clears on entry to WAIT_x and runs through WAIT_x and MEAS_x.
  - On reaching TIMEOUT_CYCLES, go directly to STORE_x with the timeout flag set.
  - Covers both cases: echo never rising, and echo stuck high.
- Conversion: distance = floor((N + CYCLES_PER_CM/2) / CYCLES_PER_CM), i.e. round half up.
  - Implemented with a prescaler plus a 3-digit BCD counter: units digit wraps 9→0 and carries; prescaler increments each echo-high clock.
  - At echo fall, if prescaler ≥ CYCLES_PER_CM/2, add one more cm.
  - Saturates at 12'h999; never wraps to 000.
- STORE_x:
  - Loads `medida_x` with the BCD count, or with 12'h999 on timeout.
  - Loads `timeout_x` (1 on timeout, else 0).
  - Other outputs hold.
- DONE: `pronto` = 1 for one cycle; set `medidas_validas`.
- `medir` outside IDLE is ignored; it is not queued. Held high continuously, it gives back-to-back cycles with one IDLE clock between them.
- A left timeout does not skip the right measurement.

## Timing
- Reset values:
  - `trigger_esq` = 0, `trigger_dir` = 0.
  - `medida_esq` = `medida_dir` = 12'h999 (far, so no false proximity alarm).
  - `timeout_esq` = `timeout_dir` = 0.
  - `ocupado` = 0, `pronto` = 0, `medidas_validas` = 0.
  - FSM in IDLE; synchronisers and counters cleared.
- Reset asserted mid-operation: at the next edge, all of the above take effect, triggers drop immediately, and any partial count is discarded.
- The trigger rises on the clock after `medir` is sampled in IDLE. It is high for exactly TRIGGER_CYCLES clocks.
- Echo-to-FSM latency is 2 clocks. N equals the raw echo width in clocks, ±1 for asynchronous phase.
- Each `medida_x` / `timeout_x` updates exactly once per cycle, in the clock after STORE_x. It is stable at all other times (no intermediate counts visible).
- `pronto` is asserted 2 clocks after the right echo's synchronised fall, or after the right timeout.
- All outputs are registered.

## Test plan
Use TRIGGER_CYCLES=4, CYCLES_PER_CM=10, TIMEOUT_CYCLES=2000, GAP_CYCLES=8 for all directed tests.
- Reset, no `medir` → `medida_esq` = `medida_dir` = 12'h999; all flags and triggers 0; `medidas_validas` = 0.
- `medir` pulse; left echo 95 clocks, right echo 105 clocks → `trigger_esq` high 4 clocks; `medida_esq` = 12'h010, `medida_dir` = 12'h011; single `pronto` pulse; `medidas_validas` = 1.
- Left echo 1234 clocks, right echo 9 clocks → `medida_esq` = 12'h123 (BCD carry), `medida_dir` = 12'h001.
- Left echo never rises; right echo 40 clocks → after 2000 clocks `timeout_esq` = 1, `medida_esq` = 12'h999, `medida_dir` = 12'h004, `pronto` pulses.
- Right echo stuck high → `timeout_dir` = 1, `medida_dir` = 12'h999.
- Reset asserted during MEAS_DIR, and `medir` pulsed while `ocupado` = 1:
  - After the reset, all outputs return to reset values, including `medidas_validas` = 0.
  - The busy-time `medir` pulse causes no second measurement cycle.

Source files
------------

// File: rtl/medidor_proximidade_duplo.sv
// Dual ultrasonic ranging sequencer: triggers left then right sensor, times each echo
// and publishes BCD centimetre distances plus timeout / validity flags.
module medidor_proximidade_duplo #(
    parameter int TRIGGER_CYCLES = 500,
    parameter int CYCLES_PER_CM  = 2941,
    parameter int TIMEOUT_CYCLES = 1_500_000,
    parameter int GAP_CYCLES     = 3_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        medir,
    input  logic        echo_esq,
    input  logic        echo_dir,
    output logic        trigger_esq,
    output logic        trigger_dir,
    output logic [11:0] medida_esq,
    output logic [11:0] medida_dir,
    output logic        timeout_esq,
    output logic        timeout_dir,
    output logic        ocupado,
    output logic        pronto,
    output logic        medidas_validas
);

    typedef enum logic [3:0] {
        IDLE,
        TRIG_ESQ,
        WAIT_ESQ,
        MEAS_ESQ,
        STORE_ESQ,
        GAP,
        TRIG_DIR,
        WAIT_DIR,
        MEAS_DIR,
        STORE_DIR,
        DONE
    } state_t;

    state_t      state, next_state;
    logic [1:0]  sync_esq, sync_dir;
    logic        prev_esq, prev_dir;
    logic [31:0] cnt;
    logic [31:0] presc;
    logic [11:0] bcd;
    logic        timed_out;
    logic        echo_s, echo_p, rise, fall;
    logic        in_wait, in_meas, timeout_hit, keep_cnt;

    // Saturating 3-digit BCD increment: 999 never wraps to 000.
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [11:0] r;
        r = v;
        if (v != 12'h999) begin
            if (v[3:0] != 4'd9) begin
                r[3:0] = v[3:0] + 4'd1;
            end else begin
                r[3:0] = 4'd0;
                if (v[7:4] != 4'd9) begin
                    r[7:4] = v[7:4] + 4'd1;
                end else begin
                    r[7:4]  = 4'd0;
                    r[11:8] = v[11:8] + 4'd1;
                end
            end
        end
        return r;
    endfunction

    // Round half up: leftover prescaler of at least half a centimetre adds one cm.
    function automatic logic [11:0] bcd_round(input logic [11:0] v, input logic [31:0] p);
        return (p >= 32'(CYCLES_PER_CM / 2)) ? bcd_inc(v) : v;
    endfunction

    assign in_wait = (state == WAIT_ESQ) || (state == WAIT_DIR);
    assign in_meas = (state == MEAS_ESQ) || (state == MEAS_DIR);
    assign echo_s  = (state == WAIT_DIR || state == MEAS_DIR) ? sync_dir[1] : sync_esq[1];
    assign echo_p  = (state == WAIT_DIR || state == MEAS_DIR) ? prev_dir    : prev_esq;
    assign rise    = echo_s & ~echo_p;
    assign fall    = ~echo_s & echo_p;

    always_comb begin
        next_state  = state;
        timeout_hit = 1'b0;
        case (state)
            IDLE:      if (medir) next_state = TRIG_ESQ;
            TRIG_ESQ:  if (cnt == 32'(TRIGGER_CYCLES - 1)) next_state = WAIT_ESQ;
            WAIT_ESQ: begin
                if (rise) begin
                    next_state = MEAS_ESQ;
                end else if (cnt >= 32'(TIMEOUT_CYCLES - 1)) begin
                    next_state  = STORE_ESQ;
                    timeout_hit = 1'b1;
                end
            end
            MEAS_ESQ: begin
                if (fall) begin
                    next_state = STORE_ESQ;
                end else if (cnt >= 32'(TIMEOUT_CYCLES - 1)) begin
                    next_state  = STORE_ESQ;
                    timeout_hit = 1'b1;
                end
            end
            STORE_ESQ: next_state = GAP;
            GAP:       if (cnt == 32'(GAP_CYCLES - 1)) next_state = TRIG_DIR;
            TRIG_DIR:  if (cnt == 32'(TRIGGER_CYCLES - 1)) next_state = WAIT_DIR;
            WAIT_DIR: begin
                if (rise) begin
                    next_state = MEAS_DIR;
                end else if (cnt >= 32'(TIMEOUT_CYCLES - 1)) begin
                    next_state  = STORE_DIR;
                    timeout_hit = 1'b1;
                end
            end
            MEAS_DIR: begin
                if (fall) begin
                    next_state = STORE_DIR;
                end else if (cnt >= 32'(TIMEOUT_CYCLES - 1)) begin
                    next_state  = STORE_DIR;
                    timeout_hit = 1'b1;
                end
            end
            STORE_DIR: next_state = DONE;
            DONE:      next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // The timeout counter keeps running from WAIT into MEAS; every other state change restarts it.
    assign keep_cnt = in_wait && (next_state == MEAS_ESQ || next_state == MEAS_DIR);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state           <= IDLE;
            sync_esq        <= 2'b00;
            sync_dir        <= 2'b00;
            prev_esq        <= 1'b0;
            prev_dir        <= 1'b0;
            cnt             <= '0;
            presc           <= '0;
            bcd             <= '0;
            timed_out       <= 1'b0;
            trigger_esq     <= 1'b0;
            trigger_dir     <= 1'b0;
            medida_esq      <= 12'h999;
            medida_dir      <= 12'h999;
            timeout_esq     <= 1'b0;
            timeout_dir     <= 1'b0;
            ocupado         <= 1'b0;
            pronto          <= 1'b0;
            medidas_validas <= 1'b0;
        end else begin
            state    <= next_state;
            sync_esq <= {sync_esq[0], echo_esq};
            sync_dir <= {sync_dir[0], echo_dir};
            prev_esq <= sync_esq[1];
            prev_dir <= sync_dir[1];

            if (state == IDLE || (next_state != state && !keep_cnt)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 32'd1;
            end

            // The rising-edge clock already counts as the first echo-high clock.
            if (in_wait && rise) begin
                presc <= 32'd1;
                bcd   <= 12'h000;
            end else if (in_meas && echo_s) begin
                if (presc == 32'(CYCLES_PER_CM - 1)) begin
                    presc <= '0;
                    bcd   <= bcd_inc(bcd);
                end else begin
                    presc <= presc + 32'd1;
                end
            end

            if (state == TRIG_ESQ || state == TRIG_DIR) begin
                timed_out <= 1'b0;
            end else if (timeout_hit) begin
                timed_out <= 1'b1;
            end

            if (state == STORE_ESQ) begin
                medida_esq  <= timed_out ? 12'h999 : bcd_round(bcd, presc);
                timeout_esq <= timed_out;
            end
            if (state == STORE_DIR) begin
                medida_dir  <= timed_out ? 12'h999 : bcd_round(bcd, presc);
                timeout_dir <= timed_out;
            end

            trigger_esq <= (next_state == TRIG_ESQ);
            trigger_dir <= (next_state == TRIG_DIR);
            ocupado     <= (next_state != IDLE);
            pronto      <= (next_state == DONE);
            if (next_state == DONE) medidas_validas <= 1'b1;
        end
    end

endmodule

// File: tb/tb_medidor_proximidade_duplo.sv
// Directed bench for medidor_proximidade_duplo: table of echo widths with expected
// distances, plus hand sequences for busy-time requests and mid-measurement reset.
module tb_medidor_proximidade_duplo;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        medir = 1'b0;
    logic        echo_esq = 1'b0;
    logic        echo_dir = 1'b0;
    logic        trigger_esq, trigger_dir, timeout_esq, timeout_dir;
    logic        ocupado, pronto, medidas_validas;
    logic [11:0] medida_esq, medida_dir;
    int          checks = 0;
    int          failures = 0;

    medidor_proximidade_duplo #(
        .TRIGGER_CYCLES(4),
        .CYCLES_PER_CM (10),
        .TIMEOUT_CYCLES(2000),
        .GAP_CYCLES    (8)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .medir          (medir),
        .echo_esq       (echo_esq),
        .echo_dir       (echo_dir),
        .trigger_esq    (trigger_esq),
        .trigger_dir    (trigger_dir),
        .medida_esq     (medida_esq),
        .medida_dir     (medida_dir),
        .timeout_esq    (timeout_esq),
        .timeout_dir    (timeout_dir),
        .ocupado        (ocupado),
        .pronto         (pronto),
        .medidas_validas(medidas_validas)
    );

    always #5 clock = ~clock;

    // w = -1: echo never rises; w = -2: echo stuck high
    typedef struct {
        int          w_esq;
        int          w_dir;
        logic [11:0] m_esq;
        logic [11:0] m_dir;
        logic        to_esq;
        logic        to_dir;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_echo(input int side, input logic v);
        if (side == 0) echo_esq = v;
        else           echo_dir = v;
    endtask

    task automatic drive_echo(input int side, input int w);
        if (w > 0) begin
            set_echo(side, 1'b1);
            repeat (w) @(negedge clock);
            set_echo(side, 1'b0);
        end else if (w == -2) begin
            set_echo(side, 1'b1);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_trigger_esq"}, 32'(trigger_esq), 32'd0);
        chk({tag, "_trigger_dir"}, 32'(trigger_dir), 32'd0);
        chk({tag, "_medida_esq"}, 32'(medida_esq), 32'h999);
        chk({tag, "_medida_dir"}, 32'(medida_dir), 32'h999);
        chk({tag, "_timeout_esq"}, 32'(timeout_esq), 32'd0);
        chk({tag, "_timeout_dir"}, 32'(timeout_dir), 32'd0);
        chk({tag, "_ocupado"}, 32'(ocupado), 32'd0);
        chk({tag, "_pronto"}, 32'(pronto), 32'd0);
        chk({tag, "_validas"}, 32'(medidas_validas), 32'd0);
    endtask

    task automatic run_vec(input int i);
        int n;
        int pc;
        string t;
        t = $sformatf("v%0d", i);
        @(negedge clock) medir = 1'b1;
        @(negedge clock) medir = 1'b0;
        chk({t, "_trig_esq_rise"}, 32'(trigger_esq), 32'd1);
        n = 0;
        while (trigger_esq && n < 100) begin n++; @(negedge clock); end
        chk({t, "_trig_esq_width"}, 32'(n), 32'd4);
        repeat (3) @(negedge clock);
        drive_echo(0, vecs[i].w_esq);
        n = 0;
        while (!trigger_dir && n < 5000) begin @(negedge clock); n++; end
        chk({t, "_trig_dir_seen"}, 32'(trigger_dir), 32'd1);
        chk({t, "_medida_esq_early"}, 32'(medida_esq), 32'(vecs[i].m_esq));
        n = 0;
        while (trigger_dir && n < 100) begin n++; @(negedge clock); end
        chk({t, "_trig_dir_width"}, 32'(n), 32'd4);
        repeat (3) @(negedge clock);
        drive_echo(1, vecs[i].w_dir);
        n = 0;
        while (!pronto && n < 5000) begin @(negedge clock); n++; end
        if (vecs[i].w_dir > 0) chk({t, "_pronto_latency"}, 32'(n), 32'd4);
        chk({t, "_pronto_seen"}, 32'(pronto), 32'd1);
        chk({t, "_validas"}, 32'(medidas_validas), 32'd1);
        pc = 1;
        n = 0;
        while (ocupado && n < 100) begin
            @(negedge clock);
            n++;
            if (pronto) pc++;
        end
        chk({t, "_pronto_count"}, 32'(pc), 32'd1);
        chk({t, "_ocupado_end"}, 32'(ocupado), 32'd0);
        chk({t, "_medida_esq"}, 32'(medida_esq), 32'(vecs[i].m_esq));
        chk({t, "_medida_dir"}, 32'(medida_dir), 32'(vecs[i].m_dir));
        chk({t, "_timeout_esq"}, 32'(timeout_esq), 32'(vecs[i].to_esq));
        chk({t, "_timeout_dir"}, 32'(timeout_dir), 32'(vecs[i].to_dir));
        echo_esq = 1'b0;
        echo_dir = 1'b0;
        repeat (5) @(negedge clock);
    endtask

    initial begin
        int n;
        int busy;
        vecs[0] = '{95,   105, 12'h010, 12'h011, 1'b0, 1'b0};
        vecs[1] = '{1234, 9,   12'h123, 12'h001, 1'b0, 1'b0};
        vecs[2] = '{-1,   40,  12'h999, 12'h004, 1'b1, 1'b0};
        vecs[3] = '{50,   -2,  12'h005, 12'h999, 1'b0, 1'b1};

        repeat (3) @(negedge clock);
        chk_reset_values("rst0");
        reset = 1'b1;
        repeat (20) @(negedge clock);
        chk_reset_values("idle");

        for (int i = 0; i < 4; i++) run_vec(i);

        // medir pulsed while busy must not queue a second cycle
        @(negedge clock) medir = 1'b1;
        @(negedge clock) medir = 1'b0;
        repeat (8) @(negedge clock);
        drive_echo(0, 30);
        n = 0;
        while (!trigger_dir && n < 5000) begin @(negedge clock); n++; end
        chk("busy_ocupado", 32'(ocupado), 32'd1);
        @(negedge clock) medir = 1'b1;
        @(negedge clock) medir = 1'b0;
        repeat (6) @(negedge clock);
        drive_echo(1, 20);
        n = 0;
        while (!pronto && n < 5000) begin @(negedge clock); n++; end
        chk("busy_pronto_seen", 32'(pronto), 32'd1);
        busy = 0;
        repeat (100) begin
            @(negedge clock);
            if (ocupado || trigger_esq || trigger_dir) busy++;
        end
        chk("busy_no_requeue", 32'(busy), 32'd0);
        chk("busy_medida_esq", 32'(medida_esq), 32'h003);
        chk("busy_medida_dir", 32'(medida_dir), 32'h002);

        // reset asserted while the right echo is being measured
        @(negedge clock) medir = 1'b1;
        @(negedge clock) medir = 1'b0;
        repeat (8) @(negedge clock);
        drive_echo(0, 30);
        n = 0;
        while (!trigger_dir && n < 5000) begin @(negedge clock); n++; end
        repeat (8) @(negedge clock);
        echo_dir = 1'b1;
        repeat (10) @(negedge clock);
        chk("mrst_validas_before", 32'(medidas_validas), 32'd1);
        reset = 1'b0;
        @(negedge clock);
        chk_reset_values("mrst");
        reset = 1'b1;
        repeat (5) @(negedge clock);
        echo_dir = 1'b0;
        busy = 0;
        repeat (50) begin
            @(negedge clock);
            if (ocupado || pronto || trigger_esq || trigger_dir) busy++;
        end
        chk("mrst_stays_idle", 32'(busy), 32'd0);
        chk("mrst_medida_dir", 32'(medida_dir), 32'h999);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
